// File: rtl/map_pixel_scaler_if.sv
// Purpose: pixel-coordinate / map-address bundle between dtg, map_pixel_scaler
//          and the colorizer.
// Signals:
//   video_on, pixel_row, pixel_column         dtg -> scaler
//   vid_addr                                  scaler -> map BRAM video port
//   pixel_row_d, pixel_column_d, out_of_map_d scaler -> colorizer (aligned with map data)
// Modports: master = coordinate source / result sink, slave = the scaler.
interface map_pixel_scaler_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned PIX_W      = 12
);
  logic                  video_on;
  logic [PIX_W-1:0]      pixel_row;
  logic [PIX_W-1:0]      pixel_column;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [PIX_W-1:0]      pixel_row_d;
  logic [PIX_W-1:0]      pixel_column_d;
  logic                  out_of_map_d;

  modport master (
    output video_on, pixel_row, pixel_column,
    input  vid_addr, pixel_row_d, pixel_column_d, out_of_map_d
  );

  modport slave (
    input  video_on, pixel_row, pixel_column,
    output vid_addr, pixel_row_d, pixel_column_d, out_of_map_d
  );
endinterface

// File: rtl/map_pixel_scaler.sv
// Purpose: turns dtg pixel_row/pixel_column into a world-map cell address using
//          incremental scale counters (no divider), and delays the pixel
//          coordinates plus an out-of-map flag so they reach the colorizer in the
//          same cycle as the map memory read data.
// Ports:
//   clk      pixel clock
//   reset_n  synchronous reset, active low
//   bus      map_pixel_scaler_if.slave: video_on/pixel_row/pixel_column in;
//            vid_addr (1 clk after the pixel), pixel_row_d/pixel_column_d/
//            out_of_map_d (1+MEM_LATENCY clks after the pixel) out.
// Build option: define MAP_SCALER_CENTER_EN to centre the map horizontally
//               (H_START=(H_ACTIVE-MAP_COLS*SCALE)/2); otherwise H_START=0.
module map_pixel_scaler #(
  parameter int unsigned MAP_COLS    = 128,
  parameter int unsigned MAP_ROWS    = 128,
  parameter int unsigned SCALE       = 6,
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned MEM_LATENCY = 1
) (
  input logic               clk,
  input logic               reset_n,
  map_pixel_scaler_if.slave bus
);

`ifdef MAP_SCALER_CENTER_EN
  localparam int unsigned H_START = (H_ACTIVE - MAP_COLS * SCALE) / 2;
`else
  localparam int unsigned H_START = 0;
`endif
  localparam int unsigned PIX_W  = 12;
  localparam int unsigned DEPTH  = 1 + MEM_LATENCY;
  localparam int unsigned SUB_W  = $clog2(SCALE);
  localparam int unsigned CIDX_W = $clog2(MAP_COLS + 1);
  localparam int unsigned RIDX_W = $clog2(MAP_ROWS + 1);
  localparam int unsigned CA_W   = $clog2(MAP_COLS);
  localparam int unsigned RA_W   = $clog2(MAP_ROWS);

  logic [SUB_W-1:0]      col_sub, col_sub_n, row_sub, row_sub_n;
  logic [CIDX_W-1:0]     col_idx, col_idx_n;
  logic [RIDX_W-1:0]     row_idx, row_idx_n;
  logic [PIX_W-1:0]      prev_row, prev_col;
  logic                  synced, synced_n;
  logic                  below_start;
  logic                  out_of_map_c;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic [PIX_W-1:0]      row_pipe [DEPTH];
  logic [PIX_W-1:0]      col_pipe [DEPTH];
  logic                  oom_pipe [DEPTH];

  // Left margin only exists when the map is centred.
  if (H_START == 0) begin : g_no_margin
    assign below_start = 1'b0;
  end else begin : g_margin
    assign below_start = bus.pixel_column < PIX_W'(H_START);
  end

  // Column counters: clear at map start, advance only on a fresh next column.
  always_comb begin
    col_sub_n = col_sub;
    col_idx_n = col_idx;
    if (bus.pixel_column == PIX_W'(H_START)) begin
      col_sub_n = '0;
      col_idx_n = '0;
    end else if ((bus.pixel_column == prev_col + PIX_W'(1)) &&
                 (bus.pixel_column > PIX_W'(H_START))) begin
      if (col_sub == SUB_W'(SCALE - 1)) begin
        col_sub_n = '0;
        if (col_idx != CIDX_W'(MAP_COLS)) col_idx_n = col_idx + CIDX_W'(1);
      end else begin
        col_sub_n = col_sub + SUB_W'(1);
      end
    end
  end

  // Row counters: touched only at a line start; frame clear has priority.
  always_comb begin
    row_sub_n = row_sub;
    row_idx_n = row_idx;
    if ((bus.pixel_column == '0) && (bus.pixel_row != prev_row)) begin
      if (bus.pixel_row == '0) begin
        row_sub_n = '0;
        row_idx_n = '0;
      end else if (row_sub == SUB_W'(SCALE - 1)) begin
        row_sub_n = '0;
        if (row_idx != RIDX_W'(MAP_ROWS)) row_idx_n = row_idx + RIDX_W'(1);
      end else begin
        row_sub_n = row_sub + SUB_W'(1);
      end
    end
  end

  // After reset, outputs stay quiet until the first line start.
  assign synced_n = synced | (bus.pixel_column == '0);

  assign out_of_map_c = !bus.video_on || below_start || !synced_n ||
                        (bus.pixel_column >= PIX_W'(H_ACTIVE)) ||
                        (col_idx_n == CIDX_W'(MAP_COLS)) ||
                        (row_idx_n == RIDX_W'(MAP_ROWS)) ||
                        (bus.pixel_row >= PIX_W'(V_ACTIVE));

  // Counter state, address register and alignment pipe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_sub  <= '0;
      col_idx  <= '0;
      row_sub  <= '0;
      row_idx  <= '0;
      prev_row <= '0;
      prev_col <= '0;
      synced   <= 1'b0;
      vid_addr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        row_pipe[i] <= '0;
        col_pipe[i] <= '0;
        oom_pipe[i] <= 1'b1;
      end
    end else begin
      col_sub  <= col_sub_n;
      col_idx  <= col_idx_n;
      row_sub  <= row_sub_n;
      row_idx  <= row_idx_n;
      prev_row <= bus.pixel_row;
      prev_col <= bus.pixel_column;
      synced   <= synced_n;
      vid_addr <= out_of_map_c ? '0 :
                  ADDR_WIDTH'({row_idx_n[RA_W-1:0], col_idx_n[CA_W-1:0]});
      row_pipe[0] <= synced_n ? bus.pixel_row : '0;
      col_pipe[0] <= synced_n ? bus.pixel_column : '0;
      oom_pipe[0] <= out_of_map_c;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        row_pipe[i] <= row_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
        oom_pipe[i] <= oom_pipe[i-1];
      end
    end
  end

  assign bus.vid_addr       = vid_addr;
  assign bus.pixel_row_d    = row_pipe[DEPTH-1];
  assign bus.pixel_column_d = col_pipe[DEPTH-1];
  assign bus.out_of_map_d   = oom_pipe[DEPTH-1];

endmodule

// File: tb/tb_map_pixel_scaler.sv
// Scoreboard bench for map_pixel_scaler: two instances (MEM_LATENCY 1 and 2)
// share one stimulus stream; the driver queues expected results, a monitor pops
// and compares them each cycle.
module tb_map_pixel_scaler;

`ifdef MAP_SCALER_CENTER_EN
  localparam bit CENTER = 1'b1;
`else
  localparam bit CENTER = 1'b0;
`endif
  localparam int HS = CENTER ? 128 : 0;
  localparam logic [13:0] FULL = 14'h3FFF;

  typedef struct {
    logic [13:0] addr;
    logic [13:0] mask;
  } addr_exp_t;

  typedef struct {
    logic [11:0] row;
    logic [11:0] col;
    logic        oom;
  } d_exp_t;

  localparam d_exp_t RST_D = '{row: 12'd0, col: 12'd0, oom: 1'b1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  map_pixel_scaler_if bus1 ();
  map_pixel_scaler_if bus2 ();

  map_pixel_scaler #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  map_pixel_scaler #(.MEM_LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  addr_exp_t aq[$];
  d_exp_t    dq1[$];
  d_exp_t    dq2[$];
  int        errors = 0;
  int        checks = 0;

  task automatic check_a(input string nm, input logic [13:0] got, input addr_exp_t e);
    checks++;
    if ((got & e.mask) !== (e.addr & e.mask)) begin
      errors++;
      $display("FAIL %s vid_addr: got %h expected %h (mask %h) t=%0t", nm, got, e.addr, e.mask, $time);
    end
  endtask

  task automatic check_d(input string nm, input logic [11:0] r, input logic [11:0] c,
                         input logic o, input d_exp_t e);
    checks++;
    if ({r, c, o} !== {e.row, e.col, e.oom}) begin
      errors++;
      $display("FAIL %s aligned: got row=%0d col=%0d oom=%b expected row=%0d col=%0d oom=%b t=%0t",
               nm, r, c, o, e.row, e.col, e.oom, $time);
    end
  endtask

  // Monitor: outputs settle after the rising edge; the driver works on falling edges.
  initial begin
    addr_exp_t ea;
    d_exp_t    ed;
    forever begin
      @(posedge clk);
      #2;
      if (aq.size() > 0) begin
        ea = aq.pop_front();
        check_a("dut1", bus1.vid_addr, ea);
        check_a("dut2", bus2.vid_addr, ea);
      end
      if (dq1.size() > 1) begin
        ed = dq1.pop_front();
        check_d("dut1", bus1.pixel_row_d, bus1.pixel_column_d, bus1.out_of_map_d, ed);
      end
      if (dq2.size() > 2) begin
        ed = dq2.pop_front();
        check_d("dut2", bus2.pixel_row_d, bus2.pixel_column_d, bus2.out_of_map_d, ed);
      end
    end
  end

  // Present one pixel and queue what it should produce.
  task automatic step(input bit rst, input bit vo, input int row, input int col,
                      input logic [13:0] ea, input logic [13:0] mask, input bit eo,
                      input bit dreset);
    d_exp_t d;
    @(negedge clk);
    reset_n = rst;
    bus1.video_on = vo;  bus1.pixel_row = 12'(row);  bus1.pixel_column = 12'(col);
    bus2.video_on = vo;  bus2.pixel_row = 12'(row);  bus2.pixel_column = 12'(col);
    aq.push_back('{addr: ea, mask: mask});
    if (!rst) begin
      dq1.delete();
      dq2.delete();
      repeat (2) dq1.push_back(RST_D);
      repeat (3) dq2.push_back(RST_D);
    end else begin
      d = dreset ? RST_D : '{row: 12'(row), col: 12'(col), oom: eo};
      dq1.push_back(d);
      dq2.push_back(d);
    end
  endtask

  // Pixel after reset but before any line start: everything at reset values.
  task automatic px_u(input bit vo, input int row, input int col);
    step(1'b1, vo, row, col, 14'h0, FULL, 1'b1, 1'b1);
  endtask

  task automatic px_lit(input int row, input int col, input logic [13:0] ea, input bit eo);
    step(1'b1, 1'b1, row, col, ea, FULL, eo, 1'b0);
  endtask

  // Expected cell from the plain coordinate mapping.
  task automatic px(input bit vo, input int row, input int col, input logic [13:0] mask);
    bit          eo;
    logic [13:0] ea;
    eo = !vo || (col < HS) || (col >= HS + 768) || (row >= 768);
    ea = eo ? 14'h0 : {7'(row / 6), 7'((col - HS) / 6)};
    step(1'b1, vo, row, col, ea, mask, eo, 1'b0);
  endtask

  task automatic do_row(input int r, input logic [13:0] mask, input bit wide);
    int  n;
    bit  full;
    n    = wide ? 1024 : 12;
    full = (mask == FULL);
    for (int c = 0; c < n; c++) begin
      if (r == 1 && c == 4) px(1'b1, r, 3, mask);  // stalled dtg repeats column 3
      if (full && r == 0 && c == 0)
        px_lit(r, c, 14'h0000, CENTER);
      else if (full && r == 767 && c == 0)
        px_lit(r, c, CENTER ? 14'h0000 : 14'h3F80, CENTER);
      else if (full && wide && r == 6 && !CENTER && c == 767)
        px_lit(r, c, 14'h00FF, 1'b0);
      else if (full && wide && r == 6 && !CENTER && c == 768)
        px_lit(r, c, 14'h0000, 1'b1);
      else if (full && wide && r == 6 && CENTER && c == 127)
        px_lit(r, c, 14'h0000, 1'b1);
      else if (full && wide && r == 6 && CENTER && c == 128)
        px_lit(r, c, 14'h0080, 1'b0);
      else if (full && wide && r == 6 && CENTER && c == 895)
        px_lit(r, c, 14'h00FF, 1'b0);
      else if (full && wide && r == 6 && CENTER && c == 896)
        px_lit(r, c, 14'h0000, 1'b1);
      else
        px(1'b1, r, c, mask);
    end
  endtask

  initial begin
    bus1.video_on = 1'b0;  bus1.pixel_row = '0;  bus1.pixel_column = '0;
    bus2.video_on = 1'b0;  bus2.pixel_row = '0;  bus2.pixel_column = '0;

    repeat (3) step(1'b0, 1'b0, 0, 0, 14'h0, FULL, 1'b1, 1'b1);

    // Vertical blanking: first unsynced, then after a line start.
    for (int c = 100; c < 105; c++) px_u(1'b0, 800, c);
    for (int c = 0; c < 6; c++) px(1'b0, 805, c, FULL);

    // Frame 0: full walk with wide rows at 6 and 767.
    for (int r = 0; r < 768; r++) do_row(r, FULL, (r == 6) || (r == 767));

    // Frame 1: reset pulse at row 300, col 400.
    for (int r = 0; r < 300; r++) do_row(r, FULL, 1'b0);
    for (int c = 0; c < 400; c++) px(1'b1, 300, c, FULL);
    step(1'b0, 1'b1, 300, 400, 14'h0, FULL, 1'b1, 1'b1);
    for (int c = 401; c < 421; c++) px_u(1'b1, 300, c);
    // Column part recovers at the next line start; rows recover at the next frame.
    for (int r = 301; r < 768; r++) do_row(r, 14'h007F, 1'b0);

    // Frame 2: fully correct again.
    for (int r = 0; r < 13; r++) do_row(r, FULL, r == 6);

    for (int c = 0; c < 4; c++) px(1'b0, 800, c, FULL);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
